// File: rtl/power_log.sv
// Integer logarithm: finds B with A**B == C by repeated multiplication of an accumulator.
// Latency: done at capture edge + 2 + k for C == A**k; + 3 + floor(log_A C) otherwise; operand errors at edge 1.
// Backpressure: none; start is only accepted in IDLE and ignored while busy.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   start    request, accepted only while idle
//   A        base (4 bits), captured with start
//   C        value to decompose (16 bits), captured with start
//   B        exponent result, held until the next result update
//   done     one-cycle completion pulse
//   erroren  result invalid (base < 2, C == 0, or C not an exact power)
//   inexact  floor result returned (only with LOG_FLOOR_EN, else tied 0)
//   busy     operation in progress
//
// Build option: define LOG_FLOOR_EN to return floor(log_A C) with inexact=1
// for non-power inputs instead of flagging an error.
module power_log (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  A,
  input  logic [15:0] C,
  output logic [3:0]  B,
  output logic        done,
  output logic        erroren,
  output logic        inexact,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Operands captured at acceptance; later input changes are ignored.
  logic [3:0]  a_q;
  logic [15:0] c_q;

  // acc holds A**exp_cnt. It only multiplies while acc < C <= 65535, and
  // A <= 15, so 20 bits always hold the product without wrapping.
  logic [19:0] acc;
  logic [3:0]  exp_cnt;

  logic chk_err;
  logic chk_one;
  logic run_hit;
  logic run_over;

  assign chk_err  = (a_q < 4'd2) || (c_q == 16'd0);
  assign chk_one  = (c_q == 16'd1);
  assign run_hit  = (acc == {4'd0, c_q});
  assign run_over = (acc >  {4'd0, c_q});

  // Status outputs decode straight from the state register so that reset
  // clears them immediately.
  assign done = (state == DONE);
  assign busy = (state == CHECK) || (state == RUN);

`ifdef LOG_FLOOR_EN
  logic inexact_q;
  assign inexact = inexact_q;
`else
  assign inexact = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (chk_err || chk_one) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (run_hit || run_over) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= 4'd0;
      c_q       <= 16'd0;
      acc       <= 20'd0;
      exp_cnt   <= 4'd0;
      B         <= 4'd0;
      erroren   <= 1'b0;
`ifdef LOG_FLOOR_EN
      inexact_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            c_q     <= C;
            erroren <= 1'b0;
`ifdef LOG_FLOOR_EN
            inexact_q <= 1'b0;
`endif
          end
        end
        CHECK: begin
          if (chk_err) begin
            erroren <= 1'b1;
            B       <= 4'd0;
          end else if (chk_one) begin
            erroren <= 1'b0;
            B       <= 4'd0;
          end else begin
            acc     <= 20'd1;
            exp_cnt <= 4'd0;
          end
        end
        RUN: begin
          if (run_hit) begin
            B <= exp_cnt;
          end else if (run_over) begin
`ifdef LOG_FLOOR_EN
            // exp_cnt has stepped one past the floor. For A=2 and
            // C > 32768 it has wrapped 16 -> 0, and the 4-bit subtract
            // still yields 15.
            B         <= exp_cnt - 4'd1;
            inexact_q <= 1'b1;
            erroren   <= 1'b0;
`else
            B         <= 4'd0;
            erroren   <= 1'b1;
`endif
          end else begin
            acc     <= acc * {16'd0, a_q};
            exp_cnt <= exp_cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_power_log.sv
// Self-checking bench for power_log: directed literal cases plus randomized
// traffic checked every cycle against a transaction-level reference model.
module tb_power_log;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  A;
  logic [15:0] C;
  logic [3:0]  B;
  logic        done;
  logic        erroren;
  logic        inexact;
  logic        busy;

  int checks = 0;
  int errors = 0;

  power_log dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .A       (A),
    .C       (C),
    .B       (B),
    .done    (done),
    .erroren (erroren),
    .inexact (inexact),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: result and the number of edges after capture at which the
  // operation completes, derived from plain arithmetic on A and C.
  function automatic void ref_op(input int a, input int c, output int rb,
                                 output bit re, output bit ri, output int lat);
    int p;
    int k;
    rb = 0; re = 1'b0; ri = 1'b0; lat = 1;
    if (a < 2 || c == 0) begin
      re = 1'b1;
    end else if (c == 1) begin
      rb = 0;
    end else begin
      p = 1;
      k = 0;
      while (p < c) begin
        p = p * a;
        k++;
      end
      lat = 2 + k;
      if (p == c) begin
        rb = k;
      end else begin
`ifdef LOG_FLOOR_EN
        rb = k - 1;
        ri = 1'b1;
`else
        re = 1'b1;
`endif
      end
    end
  endfunction

  // Transaction-level model: m_j counts edges since capture.
  bit         m_act = 1'b0;
  int         m_j   = 0;
  int         m_lat = 0;
  int         pb    = 0;
  bit         pe    = 1'b0;
  bit         pi    = 1'b0;
  logic [3:0] m_b   = 4'd0;
  bit         m_err = 1'b0;
  bit         m_inx = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 1'b0; m_j = 0; m_b = 4'd0; m_err = 1'b0; m_inx = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        ref_op(int'(A), int'(C), pb, pe, pi, m_lat);
        m_act = 1'b1; m_j = 0; m_err = 1'b0; m_inx = 1'b0;
      end
    end else begin
      m_j++;
      if (m_j == m_lat) begin
        m_b = 4'(pb); m_err = pe; m_inx = pi;
      end else if (m_j > m_lat) begin
        m_act = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_b",       32'(B),       32'(m_b));
    chk("cyc_done",    32'(done),    32'(m_act && m_j == m_lat));
    chk("cyc_busy",    32'(busy),    32'(m_act && m_j < m_lat));
    chk("cyc_erroren", 32'(erroren), 32'(m_err));
    chk("cyc_inexact", 32'(inexact), 32'(m_inx));
  end

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    start = 1'b0;
    while (m_act && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("idle_timeout", 32'(m_act), 32'd0);
  endtask

  // Issue one operation with a start pulse and check literal expectations.
  task automatic run_op(input string nm, input int a, input int c, input int eb,
                        input int ee, input int ei, input int el);
    int n;
    int bc;
    bit got;
    wait_idle();
    A = 4'(a); C = 16'(c); start = 1'b1;
    @(posedge clk);
    n = 0; bc = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      if (n == 0) begin
        start = 1'b0;
        A = 4'($urandom_range(0, 15));
        C = 16'($urandom);
      end
      if (busy) bc++;
      if (done) got = 1'b1;
      else n++;
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_latency"}, 32'(n), 32'(el));
    chk({nm, "_busy_cycles"}, 32'(bc), 32'(el));
    chk({nm, "_b"}, 32'(B), 32'(eb));
    chk({nm, "_erroren"}, 32'(erroren), 32'(ee));
    chk({nm, "_inexact"}, 32'(inexact), 32'(ei));
  endtask

  function automatic int pow_upto(input int a, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) begin
      if (p * a <= 65535) p = p * a;
    end
    return p;
  endfunction

  initial begin
    int seq[3];
    int nd;
    int cyc;
    int dcnt;
    int ta[3];
    int tc[3];
    int a;
    int c;

    reset = 1'b1; start = 1'b0; A = 4'd0; C = 16'd0;
    #1;
    chk("rst_b",       32'(B),       32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_erroren", 32'(erroren), 32'd0);
    chk("rst_inexact", 32'(inexact), 32'd0);
    @(posedge clk); #2 reset = 1'b0;

    run_op("pow2_1024",  2, 1024,  10, 0, 0, 12);
    run_op("pow2_32768", 2, 32768, 15, 0, 0, 17);
    run_op("pow15_4",    15, 50625, 4, 0, 0, 6);
`ifdef LOG_FLOOR_EN
    run_op("inexact_3_80", 3, 80, 3, 0, 1, 6);
    run_op("floor_2_40000", 2, 40000, 15, 0, 1, 18);
`else
    run_op("inexact_3_80", 3, 80, 0, 1, 0, 6);
    run_op("floor_2_40000", 2, 40000, 0, 1, 0, 18);
`endif
    run_op("base1",      1, 5,  0, 1, 0, 1);
    run_op("c_zero",     4, 0,  0, 1, 0, 1);
    run_op("c_one",      7, 1,  0, 0, 0, 1);
    run_op("pow3_9",     3, 9,  2, 0, 0, 4);

    // Held start: three back-to-back operations, operands scrambled while busy.
    wait_idle();
    ta[0] = 2; tc[0] = 16; ta[1] = 3; tc[1] = 9; ta[2] = 5; tc[2] = 125;
    A = 4'(ta[0]); C = 16'(tc[0]); start = 1'b1;
    nd = 0; cyc = 0;
    while (nd < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seq[nd] = int'(B);
        nd++;
        if (nd < 3) begin
          A = 4'(ta[nd]); C = 16'(tc[nd]);
        end else begin
          start = 1'b0;
        end
      end else if (busy) begin
        A = 4'($urandom_range(0, 15)); C = 16'($urandom);
      end
    end
    chk("held_count", 32'(nd), 32'd3);
    chk("held_b0", 32'(seq[0]), 32'd4);
    chk("held_b1", 32'(seq[1]), 32'd2);
    chk("held_b2", 32'(seq[2]), 32'd3);

    // Async reset mid-operation, between clock edges.
    wait_idle();
    A = 4'd2; C = 16'd1024; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_b",       32'(B),       32'd0);
    chk("arst_done",    32'(done),    32'd0);
    chk("arst_busy",    32'(busy),    32'd0);
    chk("arst_erroren", 32'(erroren), 32'd0);
    @(posedge clk); #2 reset = 1'b0;
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("arst_no_done", 32'(dcnt), 32'd0);
    run_op("after_rst_4_64", 4, 64, 3, 0, 0, 5);

    // Randomized traffic, checked every cycle by the model.
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #4 reset = 1'b0;
      end else begin
        start = ($urandom_range(0, 3) != 0);
        a = $urandom_range(0, 15);
        case ($urandom_range(0, 3))
          0: c = int'($urandom_range(0, 65535));
          1: c = pow_upto(a, $urandom_range(0, 16));
          2: c = int'($urandom_range(0, 3));
          default: begin
            c = pow_upto(a, $urandom_range(1, 16)) + int'($urandom_range(0, 2)) - 1;
            if (c < 0) c = 0;
            if (c > 65535) c = 65535;
          end
        endcase
        A = 4'(a); C = 16'(c);
      end
    end

    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
